// File: rtl/ro_puf_pkg.sv
// Shared types and default constants for the ring-oscillator PUF measurement path.
package ro_puf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int unsigned DEF_WINDOW      = 1024;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_SETTLE      = 4;

    // Bits needed to hold any value in 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned WIN_CNT_W = cnt_width(DEF_WINDOW);

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one asynchronous RO output, detects its rising edges and counts
// them with a saturating counter while cnt_en is high.
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_in,
    input  logic             clr,
    input  logic             cnt_en,
    output logic [CNT_W-1:0] count
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ro_in};
        hist_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en && rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/ro_pair_counter.sv
// Enables a pair of ring oscillators, counts each one's rising edges over a fixed
// window and resolves a single response bit (A faster than B).
module ro_pair_counter
    import ro_puf_pkg::*;
#(
    parameter int unsigned WINDOW      = DEF_WINDOW,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned SETTLE      = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic             response,
    output logic             tie,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b
);

    localparam int unsigned TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             ro_en_q, ro_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             resp_q, resp_d;
    logic             tie_q, tie_d;
    logic [CNT_W-1:0] count_a_q, count_a_d;
    logic [CNT_W-1:0] count_b_q, count_b_d;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             clr, cnt_en, latch;

    ro_edge_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro_in  (ro_a),
        .clr    (clr),
        .cnt_en (cnt_en),
        .count  (cnt_a)
    );

    ro_edge_counter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_cnt_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro_in  (ro_b),
        .clr    (clr),
        .cnt_en (cnt_en),
        .count  (cnt_b)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        clr     = 1'b0;
        cnt_en  = 1'b0;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // done_q high marks the cycle results appear; a start there is dropped
                if (start && !done_q) begin
                    state_d = ARM;
                    tmr_d   = TMR_W'(SETTLE - 1);
                    clr     = 1'b1;
                end
            end
            ARM: begin
                if (tmr_q == '0) begin
                    state_d = COUNT;
                    tmr_d   = TMR_W'(WINDOW - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            COUNT: begin
                cnt_en = 1'b1;
                if (tmr_q == '0) begin
                    state_d = STOP;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            STOP: begin
                latch   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ro_en_d   = (state_d == ARM) || (state_d == COUNT);
        busy_d    = (state_d != IDLE);
        done_d    = latch;
        count_a_d = latch ? cnt_a : count_a_q;
        count_b_d = latch ? cnt_b : count_b_q;
        resp_d    = latch ? (cnt_a > cnt_b) : resp_q;
        tie_d     = latch ? (cnt_a == cnt_b) : tie_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            ro_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            resp_q    <= 1'b0;
            tie_q     <= 1'b0;
            count_a_q <= '0;
            count_b_q <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            ro_en_q   <= ro_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            resp_q    <= resp_d;
            tie_q     <= tie_d;
            count_a_q <= count_a_d;
            count_b_q <= count_b_d;
        end
    end

    assign ro_en    = ro_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign response = resp_q;
    assign tie      = tie_q;
    assign count_a  = count_a_q;
    assign count_b  = count_b_q;

endmodule

// File: tb/tb_ro_pair_counter.sv
// Scoreboard bench for ro_pair_counter: a 16-bit instance and a 4-bit (saturating)
// instance share clock, reset, start and the two modelled ring oscillators.
module tb_ro_pair_counter;

    localparam int WIN = 200;
    localparam int SET = 4;
    localparam int LAT = 1 + SET + WIN + 1;

    typedef struct {
        int lo_a;
        int hi_a;
        int lo_b;
        int hi_b;
        int resp;
        int tie;
        int dcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ro_a;
    logic        ro_b_gen;
    logic        follow;
    logic        ro_b;
    int          half_a;
    int          half_b;

    logic        m_ro_en, m_busy, m_done, m_resp, m_tie;
    logic [15:0] m_count_a, m_count_b;
    logic        s_ro_en, s_busy, s_done, s_resp, s_tie;
    logic [3:0]  s_count_a, s_count_b;

    exp_t main_q[$];
    exp_t sat_q[$];
    exp_t me, se;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   en_cnt = 0;

    assign ro_b = follow ? ro_a : ro_b_gen;

    ro_pair_counter #(
        .WINDOW      (WIN),
        .CNT_W       (16),
        .SYNC_STAGES (2),
        .SETTLE      (SET)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ro_a     (ro_a),
        .ro_b     (ro_b),
        .ro_en    (m_ro_en),
        .busy     (m_busy),
        .done     (m_done),
        .response (m_resp),
        .tie      (m_tie),
        .count_a  (m_count_a),
        .count_b  (m_count_b)
    );

    ro_pair_counter #(
        .WINDOW      (WIN),
        .CNT_W       (4),
        .SYNC_STAGES (2),
        .SETTLE      (SET)
    ) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .ro_a     (ro_a),
        .ro_b     (ro_b),
        .ro_en    (s_ro_en),
        .busy     (s_busy),
        .done     (s_done),
        .response (s_resp),
        .tie      (s_tie),
        .count_a  (s_count_a),
        .count_b  (s_count_b)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // RO models: toggles land at 3 (A) and 7 (B) mod 10 ns, never on a clk edge
    initial begin
        ro_a = 1'b0;
        #3;
        forever begin
            if (half_a == 0) begin
                ro_a = 1'b0;
                #10;
            end else begin
                #(half_a) ro_a = ~ro_a;
            end
        end
    end

    initial begin
        ro_b_gen = 1'b0;
        #7;
        forever begin
            if (half_b == 0) begin
                ro_b_gen = 1'b0;
                #10;
            end else begin
                #(half_b) ro_b_gen = ~ro_b_gen;
            end
        end
    end

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    function automatic exp_t mk(input int la, input int ha, input int lb, input int hb,
                                input int r, input int t);
        exp_t e;
        e.lo_a = la; e.hi_a = ha;
        e.lo_b = lb; e.hi_b = hb;
        e.resp = r;  e.tie  = t;
        e.dcyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt = 0;
        end else begin
            if (m_ro_en) en_cnt++;
            if (m_done) begin
                if (main_q.size() == 0) begin
                    chk("main_unexpected_done", 1, 0, 0);
                end else begin
                    me = main_q.pop_front();
                    chk("main_count_a", int'(m_count_a), me.lo_a, me.hi_a);
                    chk("main_count_b", int'(m_count_b), me.lo_b, me.hi_b);
                    chk("main_response", int'(m_resp), me.resp, me.resp);
                    chk("main_tie", int'(m_tie), me.tie, me.tie);
                    chk("main_latency", cyc, me.dcyc, me.dcyc);
                    chk("main_busy_at_done", int'(m_busy), 0, 0);
                    chk("main_ro_en_cycles", en_cnt, SET + WIN, SET + WIN);
                end
                en_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_done) begin
            if (sat_q.size() == 0) begin
                chk("sat_unexpected_done", 1, 0, 0);
            end else begin
                se = sat_q.pop_front();
                chk("sat_count_a", int'(s_count_a), se.lo_a, se.hi_a);
                chk("sat_count_b", int'(s_count_b), se.lo_b, se.hi_b);
                chk("sat_response", int'(s_resp), se.resp, se.resp);
                chk("sat_tie", int'(s_tie), se.tie, se.tie);
                chk("sat_latency", cyc, se.dcyc, se.dcyc);
            end
        end
    end

    task automatic run_start(input exp_t m, input exp_t s, input bit push);
        @(negedge clk);
        start = 1'b1;
        if (push) begin
            m.dcyc = cyc + LAT;
            s.dcyc = cyc + LAT;
            main_q.push_back(m);
            sat_q.push_back(s);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!m_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!m_done) chk("done_timeout", 1, 0, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        exp_t bm, bs;
        int   b;
        rst_n  = 1'b0;
        start  = 1'b0;
        follow = 1'b0;
        half_a = 40;
        half_b = 50;
        bm = mk(24, 26, 19, 21, 1, 0);
        bs = mk(15, 15, 15, 15, 0, 1);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            chk("idle_outputs",
                int'({m_ro_en, m_busy, m_done, m_resp, m_tie, |m_count_a, |m_count_b,
                      s_ro_en, s_busy, s_done, s_resp, s_tie, |s_count_a, |s_count_b}), 0, 0);
        end

        // basic compare: A period 8 clk, B period 10 clk
        run_start(bm, bs, 1'b1);
        wait_done();

        // tie: B is a copy of A, period 10 clk
        follow = 1'b1;
        half_a = 50;
        repeat (20) @(negedge clk);
        run_start(mk(19, 21, 19, 21, 0, 1), mk(15, 15, 15, 15, 0, 1), 1'b1);
        wait_done();

        // saturation: B held low, A period 8 clk
        follow = 1'b0;
        half_a = 40;
        half_b = 0;
        repeat (20) @(negedge clk);
        run_start(mk(24, 26, 0, 0, 1, 0), mk(15, 15, 0, 0, 1, 0), 1'b1);
        wait_done();

        // starts while busy and on the done cycle are dropped
        half_b = 50;
        repeat (20) @(negedge clk);
        run_start(bm, bs, 1'b1);
        repeat (SET + 20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b = 0;
        repeat (260) begin
            @(negedge clk);
            if (m_busy || s_busy) b++;
        end
        chk("start_on_done_ignored", b, 0, 0);

        // start one cycle after done is accepted
        run_start(bm, bs, 1'b1);
        wait_done();
        run_start(bm, bs, 1'b1);
        wait_done();

        // reset mid-COUNT aborts immediately with no done
        run_start(bm, bs, 1'b0);
        repeat (SET + 50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ro_en", int'(m_ro_en), 0, 0);
        chk("rst_busy", int'(m_busy), 0, 0);
        chk("rst_done", int'(m_done), 0, 0);
        chk("rst_count_a", int'(m_count_a), 0, 0);
        chk("rst_count_b", int'(m_count_b), 0, 0);
        chk("rst_response", int'(m_resp), 0, 0);
        chk("rst_sat_count_a", int'(s_count_a), 0, 0);
        chk("rst_sat_tie", int'(s_tie), 0, 0);
        repeat (50) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_start(bm, bs, 1'b1);
        wait_done();

        repeat (10) @(negedge clk);
        chk("main_pending_results", main_q.size(), 0, 0);
        chk("sat_pending_results", sat_q.size(), 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
